// File: rtl/lcd_pkg.sv
// lcd_pkg: sequencer states, writer phases and
// HD44780 command bytes shared by the lcd_ctrl slice.
package lcd_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        INIT,
        IDLE,
        ADDR,
        CHAR
    } state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_HIGH,
        WR_WAIT
    } wr_state_t;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_ON    = 8'h0C;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_LINE0 = 8'h80;
    localparam logic [7:0] CMD_LINE1 = 8'hC0;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] c;
        unique case (step)
            2'd0:    c = CMD_FUNC;
            2'd1:    c = CMD_ON;
            2'd2:    c = CMD_CLR;
            default: c = CMD_ENTRY;
        endcase
        return c;
    endfunction

    // Counts are zero-based, so the largest wait needs
    // only $clog2 of itself.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: text-source fetch port plus LCD pins.
// master = sequencer side, slave = text source / panel side.
interface lcd_ctrl_if;
    logic       char_line;
    logic [3:0] char_idx;
    logic [7:0] char_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output char_line, char_idx,
        output lcd_rs, lcd_rw, lcd_en, lcd_data,
        input  char_data
    );

    modport slave (
        input  char_line, char_idx,
        input  lcd_rs, lcd_rw, lcd_en, lcd_data,
        output char_data
    );
endinterface

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one byte = setup, E high, E low wait.
// start/rs/wr_byte/long_wait in; done, lcd_en/rs/data out.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int E_PULSE  = 25,
    parameter int CMD_WAIT = 2000,
    parameter int CLR_WAIT = 82000,
    parameter int CW       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] wr_byte,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    localparam logic [CW-1:0] E_LAST = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] N_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLR_WAIT - 1);

    wr_state_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_q, long_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic [CW-1:0] w_last;

    assign w_last = long_q ? C_LAST : N_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= WR_IDLE;
            cnt_q  <= '0;
            long_q <= 1'b0;
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            long_q <= long_d;
            en_q   <= en_d;
            rs_q   <= rs_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        long_d = long_q;
        en_d   = en_q;
        rs_d   = rs_q;
        data_d = data_q;
        done   = 1'b0;
        unique case (st_q)
            WR_SETUP: begin
                st_d  = WR_HIGH;
                cnt_d = '0;
                en_d  = 1'b1;
            end
            WR_HIGH: begin
                if (cnt_q == E_LAST) begin
                    st_d  = WR_WAIT;
                    cnt_d = '0;
                    en_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt_q == w_last) begin
                    done = 1'b1;
                    st_d = WR_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // The caller restarts in the done cycle, so a start
        // overrides the return to idle with no gap.
        if (start) begin
            st_d   = WR_SETUP;
            cnt_d  = '0;
            rs_d   = rs;
            data_d = wr_byte;
            long_d = long_wait;
        end
    end

    assign lcd_en   = en_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 16x2 sequencer (power-up, init, frames).
// clk/rst/refresh in; busy, frame_done out; bus = fetch + pins.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int E_PULSE   = 25,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000,
    parameter int INIT_WAIT = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    lcd_ctrl_if.master bus,
    output logic       busy,
    output logic       frame_done
);
    localparam int CW = cnt_width(INIT_WAIT, CLR_WAIT, CMD_WAIT);
    localparam logic [CW-1:0] IW_LAST = CW'(INIT_WAIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] pw_q, pw_d;
    logic [1:0]    step_q, step_d;
    logic [3:0]    col_q, col_d;
    logic          line_q, line_d;
    logic          pend_q, pend_d;
    logic          fd_q, fd_d;

    logic       start;
    logic       s_rs;
    logic [7:0] s_byte;
    logic       wr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= POWERUP;
            pw_q    <= '0;
            step_q  <= 2'd0;
            col_q   <= 4'd0;
            line_q  <= 1'b0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            step_q  <= step_d;
            col_q   <= col_d;
            line_q  <= line_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
        end
    end

    // col_q is the next column to fetch; it advances when
    // its byte is started, so the address is already set up
    // for the following fetch. Wrapping to 0 ends a line.
    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        step_d  = step_q;
        col_d   = col_q;
        line_d  = line_q;
        pend_d  = pend_q;
        fd_d    = 1'b0;
        start   = 1'b0;
        s_rs    = 1'b0;
        s_byte  = 8'h00;
        if (state_q != IDLE && refresh) pend_d = 1'b1;
        unique case (state_q)
            POWERUP: begin
                if (pw_q == IW_LAST) begin
                    start   = 1'b1;
                    s_byte  = CMD_FUNC;
                    step_d  = 2'd0;
                    state_d = INIT;
                end else begin
                    pw_d = pw_q + 1'b1;
                end
            end
            INIT: begin
                if (wr_done) begin
                    if (step_q == 2'd3) begin
                        pend_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        start  = 1'b1;
                        s_byte = init_cmd(step_q + 2'd1);
                        step_d = step_q + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (pend_q || refresh) begin
                    pend_d  = 1'b0;
                    line_d  = 1'b0;
                    col_d   = 4'd0;
                    start   = 1'b1;
                    s_byte  = CMD_LINE0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (wr_done) begin
                    start   = 1'b1;
                    s_rs    = 1'b1;
                    s_byte  = bus.char_data;
                    col_d   = col_q + 4'd1;
                    state_d = CHAR;
                end
            end
            CHAR: begin
                if (wr_done) begin
                    if (col_q != 4'd0) begin
                        start  = 1'b1;
                        s_rs   = 1'b1;
                        s_byte = bus.char_data;
                        col_d  = col_q + 4'd1;
                    end else if (!line_q) begin
                        line_d  = 1'b1;
                        start   = 1'b1;
                        s_byte  = CMD_LINE1;
                        state_d = ADDR;
                    end else begin
                        line_d  = 1'b0;
                        fd_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = POWERUP;
        endcase
    end

    lcd_byte_writer #(
        .E_PULSE  (E_PULSE),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT),
        .CW       (CW)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rs        (s_rs),
        .wr_byte   (s_byte),
        .long_wait (!s_rs && s_byte == CMD_CLR),
        .done      (wr_done),
        .lcd_en    (bus.lcd_en),
        .lcd_rs    (bus.lcd_rs),
        .lcd_data  (bus.lcd_data)
    );

    assign bus.char_line = line_q;
    assign bus.char_idx  = 4'd15 - col_q;
    assign bus.lcd_rw    = 1'b0;
    assign busy          = (state_q != IDLE);
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: expected byte stream per frame plus a bus
// monitor checking timing, stability and frame pacing.
module tb_lcd_ctrl;
    localparam int EP    = 2;
    localparam int CWT   = 4;
    localparam int CL    = 8;
    localparam int IW    = 10;
    localparam int FRAME = 34 * (1 + EP + CWT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic refresh = 1'b0;
    logic busy;
    logic frame_done;
    logic [7:0] txt [2][16];

    lcd_ctrl_if bus();
    assign bus.char_data = txt[bus.char_line][bus.char_idx];

    lcd_ctrl #(
        .E_PULSE   (EP),
        .CMD_WAIT  (CWT),
        .CLR_WAIT  (CL),
        .INIT_WAIT (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .refresh    (refresh),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rs;
        bit [7:0] d;
        int       gap;
        bit       last;
    } exp_t;

    exp_t q[$];
    logic [7:0] obs_d[$];
    int obs_gap[$];
    int checks = 0;
    int errors = 0;
    int frames_exp = 0;
    int frames_seen = 0;
    int last_len = -1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic push_b(input bit rs, input bit [7:0] d,
                          input int gap, input bit last);
        exp_t e;
        e.rs = rs;
        e.d = d;
        e.gap = gap;
        e.last = last;
        q.push_back(e);
    endtask

    // Gap = E-low samples before E rises: wait of the previous
    // byte plus one setup cycle (power-up wait for the first).
    task automatic push_init();
        push_b(0, 8'h38, IW + 1, 0);
        push_b(0, 8'h0C, CWT + 1, 0);
        push_b(0, 8'h01, CWT + 1, 0);
        push_b(0, 8'h06, CL + 1, 0);
    endtask

    task automatic push_frame();
        frames_exp++;
        for (int l = 0; l < 2; l++) begin
            push_b(0, (l == 0) ? 8'h80 : 8'hC0,
                   (l == 0) ? -1 : CWT + 1, 0);
            for (int c = 0; c < 16; c++)
                push_b(1, txt[l][15 - c], CWT + 1,
                       (l == 1) && (c == 15));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        refresh = 1'b1;
        step(1);
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while ((busy || q.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, n < budget, 1);
        step(2);
    endtask

    int  cyc = 0;
    bit  prev_en = 0, prev_busy = 1, prev_fd = 0;
    bit  fresh = 1, need_rise = 0, end_seen = 0, have_fs = 0;
    int  en_len = 0, gap = 0, fstart = 0;
    logic       prev_rs;
    logic [7:0] prev_d;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_en = 0;
            prev_busy = 1;
            prev_fd = 0;
            fresh = 1;
            need_rise = 0;
            have_fs = 0;
            en_len = 0;
            gap = 0;
        end else begin
            chk("rw", bus.lcd_rw, 0);
            if (need_rise) begin
                chk("setup_then_e", bus.lcd_en, 1);
                need_rise = 0;
            end
            if (!fresh && (bus.lcd_rs !== prev_rs ||
                           bus.lcd_data !== prev_d)) begin
                chk("change_while_e", bus.lcd_en, 0);
                need_rise = 1;
            end
            if (bus.lcd_en) begin
                if (!prev_en) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte got=%0h want=none",
                                 bus.lcd_data);
                    end else begin
                        e = q.pop_front();
                        chk("rs", bus.lcd_rs, e.rs);
                        chk("data", bus.lcd_data, e.d);
                        if (e.gap >= 0) chk("gap", gap, e.gap);
                        if (e.last) end_seen = 1;
                    end
                    obs_d.push_back(bus.lcd_data);
                    obs_gap.push_back(gap);
                    en_len = 0;
                end
                en_len++;
            end else begin
                if (prev_en) begin
                    chk("e_high_len", en_len, EP);
                    gap = 0;
                end
                gap++;
            end
            if (busy && !prev_busy) begin
                fstart = cyc;
                have_fs = 1;
            end
            if (frame_done) begin
                frames_seen++;
                chk("fd_width", prev_fd, 0);
                chk("fd_after_last", end_seen, 1);
                end_seen = 0;
                if (have_fs) begin
                    chk("frame_len", cyc - fstart, FRAME);
                    last_len = cyc - fstart;
                    have_fs = 0;
                end
            end
            prev_en = bus.lcd_en;
            prev_busy = busy;
            prev_fd = frame_done;
            prev_rs = bus.lcd_rs;
            prev_d = bus.lcd_data;
            fresh = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        for (int l = 0; l < 2; l++)
            for (int j = 0; j < 16; j++)
                txt[l][j] = 8'h40 + 8'(j);
        push_init();
        push_frame();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_en", bus.lcd_en, 0);
        chk("rst_idx", bus.char_idx, 4'hF);
        rst = 1'b0;
        wait_idle(4000, "init_idle");

        chk("lit_count", obs_d.size() >= 38, 1);
        if (obs_d.size() >= 38) begin
            chk("lit_b0", obs_d[0], 8'h38);
            chk("lit_b1", obs_d[1], 8'h0C);
            chk("lit_b2", obs_d[2], 8'h01);
            chk("lit_b3", obs_d[3], 8'h06);
            chk("lit_addr0", obs_d[4], 8'h80);
            chk("lit_first_ch", obs_d[5], 8'h4F);
            chk("lit_last_ch0", obs_d[20], 8'h40);
            chk("lit_addr1", obs_d[21], 8'hC0);
            chk("lit_l1_first", obs_d[22], 8'h4F);
            chk("lit_l1_last", obs_d[37], 8'h40);
            chk("lit_pwr_gap", obs_gap[0], 11);
            chk("lit_cmd_gap", obs_gap[1], 5);
            chk("lit_clr_gap", obs_gap[3], 9);
        end
        chk("lit_frame_len", last_len, 238);
        chk("lit_frames", frames_seen, 1);
        chk("idle_busy", busy, 0);

        for (int it = 0; it < 4; it++) begin
            for (int l = 0; l < 2; l++)
                for (int j = 0; j < 16; j++)
                    txt[l][j] = 8'($urandom_range(32, 126));
            step($urandom_range(1, 20));
            push_frame();
            pulse();
            chk("refresh_busy", busy, 1);
            step($urandom_range(5, 60));
            k = (it == 0) ? 3 : $urandom_range(1, 3);
            for (int p = 0; p < k; p++) begin
                pulse();
                step($urandom_range(1, 40));
            end
            push_frame();
            wait_idle(2000, "merge_idle");
        end

        push_frame();
        pulse();
        n = 0;
        while (!frame_done && n < 1000) begin
            step(1);
            n++;
        end
        chk("fd_seen", n < 1000, 1);
        push_frame();
        pulse();
        n = 0;
        while (!busy && n < 2) begin
            step(1);
            n++;
        end
        chk("fd_refresh_restart", busy, 1);
        wait_idle(2000, "fd_idle");

        push_frame();
        pulse();
        step($urandom_range(10, 150));
        n = 0;
        while (!(bus.lcd_en && bus.lcd_rs) && n < 100) begin
            step(1);
            n++;
        end
        chk("char_e_seen", n < 100, 1);
        rst = 1'b1;
        step(1);
        chk("abort_en", bus.lcd_en, 0);
        chk("abort_busy", busy, 1);
        chk("abort_idx", bus.char_idx, 4'hF);
        chk("abort_line", bus.char_line, 0);
        chk("abort_data", bus.lcd_data, 8'h00);
        chk("abort_rs", bus.lcd_rs, 0);
        chk("abort_fd", frame_done, 0);
        rst = 1'b0;
        q.delete();
        frames_exp--;
        push_init();
        push_frame();
        wait_idle(4000, "reinit_idle");

        step(300);
        chk("queue_empty", q.size(), 0);
        chk("frame_count", frames_seen, frames_exp);
        chk("final_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Sequencer that drives an HD44780-compatible 16x2 character LCD from the combinational text generator. After power-up it runs the controller init sequence, then on each refresh request it streams both text lines to the panel. For each character it presents a (line, index) address to the text source and samples the returned byte. It sits between the text generator and the LCD pins, and owns all bus timing: RS, RW, E and data.

## Interface
- E_PULSE, 25: cycles E is held high per byte (500 ns at 50 MHz).
- CMD_WAIT, 2000: cycles E is held low after a normal byte.
- CLR_WAIT, 82000: cycles E is held low after the clear command (0x01).
- INIT_WAIT, 2000000: power-up delay in cycles before the first command.
- clk, in, 1: the block's only clock.
- rst, in, 1: reset. Synchronous, active-high.
- refresh, in, 1: one-cycle request to redraw both lines.
- char_data, in, 8: character byte from the text source. Combinational in char_line/char_idx.
- char_line, out, 1: line being fetched (0 = top).
- char_idx, out, 4: index being fetched.
- lcd_rs, out, 1: 0 = command, 1 = data.
- lcd_rw, out, 1: tied 0. The block only writes.
- lcd_en, out, 1: LCD enable strobe.
- lcd_data, out, 8: LCD data bus.
- busy, out, 1: high from reset until IDLE is reached, and while a frame is in progress.
- frame_done, out, 1: one-cycle pulse after the last character of line 1 completes.

## Operation
- Reset values:
  - lcd_en, lcd_rs, lcd_rw, frame_done = 0.
  - lcd_data = 0x00, char_line = 0, char_idx = 15.
  - busy = 1.
  - FSM = POWERUP. The refresh-pending flag is cleared.
- POWERUP: count INIT_WAIT cycles, then go to INIT.
- INIT: write four commands in order: 0x38, 0x0C, 0x01 (uses CLR_WAIT), 0x06. After the last one, set pending = 1, so the first frame draws automatically.
- IDLE: busy = 0. When pending or refresh is high, clear pending, set busy and go to ADDR.
- ADDR: write command 0x80 for line 0 or 0xC0 for line 1, then go to CHAR with column = 0.
- CHAR: for column c (0..15), drive char_idx = 15 − c and char_line = current line. Write char_data with rs = 1.
  - After column 15 on line 0, go to ADDR for line 1.
  - After column 15 on line 1, pulse frame_done and return to IDLE.
- A refresh pulse seen outside IDLE sets pending. Only one pending request is held; further pulses merge into it.
- A refresh arriving in the same cycle as frame_done is not lost. It is either latched into pending or taken directly in IDLE on the next cycle.
- rst asserted at any point aborts immediately: all outputs go to their reset values, and the power-up wait restarts from zero.

## Timing
- A byte write is accepted at edge T. It then occupies 1 + E_PULSE + WAIT cycles from T+1:
  - 1 setup cycle with E low and rs/data valid;
  - E_PULSE cycles with E high;
  - WAIT cycles with E low, where WAIT = CLR_WAIT for 0x01 and CMD_WAIT otherwise.
- lcd_rs and lcd_data stay stable from the setup cycle through the end of WAIT. They change only at the next setup cycle.
- char_data is sampled at the end of the cycle before setup. char_line/char_idx are stable for at least that whole cycle.
- Writer done is asserted in the last WAIT cycle. The controller issues the next start in that same cycle, so there are no idle gaps within a frame.
- Frame length = 34 bytes × (1 + E_PULSE + CMD_WAIT) cycles, from leaving IDLE to the frame_done pulse.
- The wait counter is sized by $clog2 of the largest of INIT_WAIT, CLR_WAIT and CMD_WAIT. The count is compared against parameter − 1 (counts are zero-based).

## Structure
- Package lcd_pkg holds:
  - the FSM state enum (POWERUP, INIT, IDLE, ADDR, CHAR);
  - the command constants (CMD_FUNC 0x38, CMD_ON 0x0C, CMD_CLR 0x01, CMD_ENTRY 0x06, CMD_LINE0 0x80, CMD_LINE1 0xC0).
- Sub-module lcd_byte_writer handles the single-byte timing:
  - inputs: start, rs, byte, long_wait;
  - outputs: done, lcd_en, lcd_rs, lcd_data.
- lcd_ctrl holds the sequencing FSM, the init-step counter, the column and line counters, and the pending flag.

## Test plan
All scenarios use E_PULSE=2, CMD_WAIT=4, CLR_WAIT=8, INIT_WAIT=10.
- Reset release, no stimulus:
  - lcd_en stays 0 for 10 cycles;
  - bytes 0x38, 0x0C, 0x01, 0x06 appear with rs = 0;
  - the E-low gap after 0x01 is 8 cycles, and 4 cycles after the others;
  - the auto frame follows and busy falls after frame_done.
- Text source returns {line, idx} as ASCII '@' + idx:
  - the bus shows 0x80, then 'O'..'@' with rs = 1;
  - then 0xC0 and the same 16 characters;
  - the frame takes 34 × 7 = 238 cycles.
- Refresh pulsed three times mid-frame: exactly one extra frame runs immediately after frame_done.
- Refresh in the same cycle as frame_done: the next frame starts within 2 cycles and there is no missed redraw.
- rst pulsed during a character's E-high phase:
  - next cycle, lcd_en = 0, busy = 1, char_idx = 15;
  - the full INIT_WAIT plus init sequence repeats.
- Throughout all runs:
  - every E-high window is exactly 2 cycles;
  - lcd_data/lcd_rs never change while lcd_en = 1 or during the wait;
  - lcd_rw is always 0.
